uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (5..9).
REQ-002 SHALL have parameter OVERSAMPLING_RATE, default 8, meaning oversample ticks per bit (even, >=4).
REQ-003 SHALL have port clk_in, input, 1 bit: system clock, the only clock; all state SHALL be clocked on its rising edge.
REQ-004 SHALL have port nrst_in, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port os_clk_in, input, 1 bit: oversample clock level from the upstream baud generator, synchronous to clk_in; each rising edge is one tick.
REQ-006 SHALL have port rx_in, input, 1 bit: serial line, asynchronous, idle high.
REQ-007 SHALL have port data_out, output, DATA_BITS wide: last received payload.
REQ-008 SHALL have port data_valid, output, 1 bit: one-clk_in-cycle pulse when data_out updates.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port parity_err, output, 1 bit: one-cycle pulse on a parity mismatch.

Function
REQ-011 SHALL derive tick as a one-cycle strobe on os_clk_in 0->1, using a registered copy of os_clk_in; all counters advance only on tick.
REQ-012 SHALL pass rx_in through sub-module uart_rx_sync (2-flop synchronizer, reset value 1) before any use.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP and BREAK.
REQ-014 IDLE: synchronized rx = 0 on a tick -> START with tick counter cleared.
REQ-015 START: after OVERSAMPLING_RATE/2 ticks, if rx = 0 -> DATA with counter cleared, else -> IDLE (glitch rejection; no output).
REQ-016 DATA: sample rx every OVERSAMPLING_RATE ticks (mid-bit), shift in LSB first; after DATA_BITS samples -> PARITY or STOP.
REQ-017 STOP: sample after OVERSAMPLING_RATE ticks; rx = 1 -> load data_out, pulse data_valid, -> IDLE; rx = 0 -> pulse frame_err, leave data_out unchanged, -> BREAK.
REQ-018 BREAK: stay until rx = 1 is sampled on a tick, then -> IDLE; a held-low line SHALL yield exactly one frame_err.
REQ-019 Output pulses SHALL assert the clk_in cycle after the tick on which the deciding sample is taken.
REQ-020 data_out SHALL hold its value until the next good frame; there is no handshake, and a frame not consumed is overwritten.
REQ-021 A start edge seen on the tick after STOP->IDLE SHALL be accepted, so back-to-back frames are received without loss.
REQ-022 Tick counter width SHALL be $clog2(OVERSAMPLING_RATE) bits and bit counter width $clog2(DATA_BITS+1) bits; both SHALL wrap only by explicit clear.

Reset
REQ-023 While nrst_in = 0: state = IDLE, counters = 0, shift register = 0, data_out = 0, data_valid = 0, frame_err = 0, parity_err = 0, synchronizer and os_clk_in copy = 1 and 0 respectively.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, reception SHALL restart only on a fresh start edge.

Configuration
REQ-025 With macro UART_RX_PARITY_EN defined, PARITY state SHALL sample one even-parity bit after the data bits; on mismatch, parity_err SHALL pulse with the STOP outcome, and data_valid SHALL NOT pulse for that frame.
REQ-026 Without UART_RX_PARITY_EN, PARITY state and its logic SHALL be absent, and parity_err SHALL be tied 0.

Structure
REQ-027 State encoding and the parity-enable constant SHALL live in shared package uart_pkg, reused by the future uart_tx.
REQ-028 Sub-module uart_rx_sync SHALL be the only sub-module.

Verification (DATA_BITS=8, OVERSAMPLING_RATE=8, os_clk_in from baud generator at 230400 baud)
REQ-029 Send 0xA5, stop=1 -> data_out=0xA5, one data_valid pulse, frame_err=0.
REQ-030 rx low for 3 ticks then high -> no pulses, state returns IDLE, data_out unchanged.
REQ-031 Send 0x3C with stop=0, then hold low 20 bit times -> one frame_err, no data_valid; next 0x5A after line high -> data_out=0x5A.
REQ-032 Back-to-back 0x00, 0xFF with zero idle -> two data_valid pulses, values 0x00 then 0xFF.
REQ-033 nrst_in pulsed low during bit 4 of 0x77 -> all outputs 0, no pulse; following 0x12 -> data_out=0x12.
REQ-034 UART_RX_PARITY_EN defined, 0x03 sent with parity bit 1 -> parity_err pulse, no data_valid; with parity 0 -> data_out=0x03, data_valid pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and the parity-enable constant.
// Parity support is compiled in only when macro UART_RX_PARITY_EN is defined.
package uart_pkg;

`ifdef UART_RX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // Fixed codes keep the encoding stable whether or not PARITY exists.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level (1).
module uart_rx_sync (
    input  logic clk_in,
    input  logic nrst_in,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit glitch rejection, mid-bit sampling, break handling.
// Optional even parity is enabled with macro UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS         = 8,
    parameter int OVERSAMPLING_RATE = 8
) (
    input  logic                 clk_in,
    input  logic                 nrst_in,
    input  logic                 os_clk_in,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int TW = $clog2(OVERSAMPLING_RATE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLING_RATE - 1);
    localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLING_RATE / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    uart_state_t          state, state_nxt;
    logic                 os_prev, tick, rx_s;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 half_done, bit_done, last_bit;
    logic                 cnt_clr, cnt_inc, bit_clr, shift_en, frame_good, frame_bad;

    uart_rx_sync u_sync (
        .clk_in  (clk_in),
        .nrst_in (nrst_in),
        .d       (rx_in),
        .q       (rx_s)
    );

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) os_prev <= 1'b0;
        else          os_prev <= os_clk_in;
    end

    assign tick      = os_clk_in & ~os_prev;
    assign half_done = tick && (tick_cnt == MID_TICK);
    assign bit_done  = tick && (tick_cnt == LAST_TICK);
    assign last_bit  = (bit_cnt == LAST_BIT);

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (tick && !rx_s) state_nxt = START;
            START: if (half_done) state_nxt = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (bit_done && last_bit) state_nxt = PARITY;
            PARITY: if (bit_done) state_nxt = STOP;
`else
            DATA:  if (bit_done && last_bit) state_nxt = STOP;
`endif
            STOP:  if (bit_done) state_nxt = rx_s ? IDLE : BREAK;
            BREAK: if (tick && rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic par_sample, par_bit, par_bad, par_fail;
    assign par_bad = ^{shreg, par_bit};
`endif

    always_comb begin
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        bit_clr    = 1'b0;
        shift_en   = 1'b0;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_sample = 1'b0;
        par_fail   = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                bit_clr = 1'b1;
            end
            START: begin
                if (half_done) cnt_clr = 1'b1;
                else           cnt_inc = tick;
            end
            DATA: begin
                if (bit_done) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                end else begin
                    cnt_inc = tick;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    cnt_clr    = 1'b1;
                    par_sample = 1'b1;
                end else begin
                    cnt_inc = tick;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    cnt_clr   = 1'b1;
                    frame_bad = ~rx_s;
`ifdef UART_RX_PARITY_EN
                    frame_good = rx_s & ~par_bad;
                    par_fail   = PARITY_EN & par_bad;
`else
                    frame_good = rx_s;
`endif
                end else begin
                    cnt_inc = tick;
                end
            end
            default: cnt_clr = 1'b1;
        endcase
    end

    // Outputs are registered so each pulse lands the cycle after its deciding tick.
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (cnt_clr)      tick_cnt <= '0;
            else if (cnt_inc) tick_cnt <= tick_cnt + 1'b1;
            if (shift_en) begin
                shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            end else if (bit_clr) begin
                bit_cnt <= '0;
            end
            if (frame_good) data_out <= shreg;
            data_valid <= frame_good;
            frame_err  <= frame_bad;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (par_sample) par_bit <= rx_s;
            parity_err <= par_fail;
        end
    end
`else
    assign parity_err = PARITY_EN;
`endif

endmodule
